// File: rtl/game_flow_sequencer_pkg.sv
// Shared screen codes, widths and player-rotation helpers
// for the Breakout flow sequencer.
package game_flow_sequencer_pkg;

    localparam int MAX_PLAYERS = 4;
    localparam int PLAYER_W = 2;
    localparam int NSEL_W = 3;

    typedef enum logic [2:0] {
        S_INTRO         = 3'd0,
        S_IN_GAME       = 3'd1,
        S_GAME_OVER     = 3'd2,
        S_PAUSED        = 3'd3,
        S_PLAYER_SWITCH = 3'd4,
        S_ATTRACT       = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // First unfinished index after cur, wrapping within the selected count.
    function automatic logic [PLAYER_W-1:0] next_player(
        input logic [PLAYER_W-1:0] cur,
        input logic [NSEL_W-1:0] num,
        input logic [MAX_PLAYERS-1:0] mask
    );
        logic [PLAYER_W-1:0] r;
        int idx;
        r = cur;
        for (int i = MAX_PLAYERS; i >= 1; i--) begin
            idx = (int'(cur) + i) % int'(num);
            if (!mask[idx[1:0]])
                r = idx[PLAYER_W-1:0];
        end
        return r;
    endfunction

    function automatic logic all_done(
        input logic [MAX_PLAYERS-1:0] mask,
        input logic [NSEL_W-1:0] num
    );
        logic d;
        d = 1'b1;
        for (int i = 0; i < MAX_PLAYERS; i++)
            if (i < int'(num) && !mask[i])
                d = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/game_flow_sequencer_debouncer.sv
// Two-flop synchroniser, stability counter and rising-edge pulse.
// Level resets to pressed so a button held through reset must be released first.
module game_flow_sequencer_debouncer #(
    parameter int DEBOUNCE_CYCLES = 400000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic s1;
    logic s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= s2;
                rise  <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/game_flow_sequencer.sv
// Breakout screen/flow sequencer: intro, attract, turns, pause, game over.
// Drives renderer screen select and controller reset/pause/context swap.
module game_flow_sequencer
    import game_flow_sequencer_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int SWITCH_FRAMES   = 120,
    parameter int GAMEOVER_FRAMES = 300,
    parameter int ATTRACT_FRAMES  = 1800
) (
    input  logic                CLK_40M,
    input  logic                reset,
    input  logic                FRAME_DONE,
    input  logic                BTN_START,
    input  logic                BTN_LEFT,
    input  logic                BTN_RIGHT,
    input  logic                SW_PAUSE,
    input  logic                LIFE_LOST,
    input  logic                GAME_OVER,
    output logic [2:0]          SCREEN,
    output logic [PLAYER_W-1:0] ACTIVE_PLAYER,
    output logic [NSEL_W-1:0]   NUM_SELECTED,
    output logic                CTRL_RESET,
    output logic                CTRL_PAUSE,
    output logic                CTX_SWAP
);

    localparam int FMAX = max3(SWITCH_FRAMES, GAMEOVER_FRAMES, ATTRACT_FRAMES);
    localparam int FW = $clog2(FMAX + 1);
    localparam logic [FW-1:0] F_SAT = FW'(FMAX);
    localparam logic [FW-1:0] SW_LAST = FW'(SWITCH_FRAMES - 1);
    localparam logic [FW-1:0] GO_LAST = FW'(GAMEOVER_FRAMES - 1);
    localparam logic [FW-1:0] AT_LAST = FW'(ATTRACT_FRAMES - 1);
    localparam logic [NSEL_W-1:0] NP_V = NSEL_W'(NUM_PLAYERS);

    logic start_ev, left_ev, right_ev;
    logic start_lvl, left_lvl, right_lvl, pause_lvl, pause_rise;
    logic unused_bits;

    game_flow_sequencer_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(CLK_40M), .reset(reset), .raw(BTN_START),
        .level(start_lvl), .rise(start_ev)
    );
    game_flow_sequencer_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk(CLK_40M), .reset(reset), .raw(BTN_LEFT),
        .level(left_lvl), .rise(left_ev)
    );
    game_flow_sequencer_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk(CLK_40M), .reset(reset), .raw(BTN_RIGHT),
        .level(right_lvl), .rise(right_ev)
    );
    game_flow_sequencer_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk(CLK_40M), .reset(reset), .raw(SW_PAUSE),
        .level(pause_lvl), .rise(pause_rise)
    );

    assign unused_bits = ^{start_lvl, left_lvl, right_lvl, pause_rise};

    state_e state, state_n;
    logic [PLAYER_W-1:0] active, active_n;
    logic [NSEL_W-1:0] nsel, nsel_n;
    logic [MAX_PLAYERS-1:0] mask, mask_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic ctx_n, creset_n, cpause_n;

    always_ff @(posedge CLK_40M) begin
        if (reset) begin
            state      <= S_INTRO;
            active     <= '0;
            nsel       <= NSEL_W'(1);
            mask       <= '0;
            fcnt       <= '0;
            CTX_SWAP   <= 1'b0;
            CTRL_RESET <= 1'b1;
            CTRL_PAUSE <= 1'b0;
        end else begin
            state      <= state_n;
            active     <= active_n;
            nsel       <= nsel_n;
            mask       <= mask_n;
            fcnt       <= fcnt_n;
            CTX_SWAP   <= ctx_n;
            CTRL_RESET <= creset_n;
            CTRL_PAUSE <= cpause_n;
        end
    end

    always_comb begin
        state_n  = state;
        active_n = active;
        nsel_n   = nsel;
        mask_n   = mask;
        ctx_n    = 1'b0;
        fcnt_n   = (FRAME_DONE && fcnt != F_SAT) ? fcnt + FW'(1) : fcnt;
        unique case (state)
            S_INTRO: begin
                if (start_ev) begin
                    state_n  = S_IN_GAME;
                    active_n = '0;
                    mask_n   = '0;
                end else if (left_ev || right_ev) begin
                    fcnt_n = '0;
                    if (right_ev && nsel != NP_V)
                        nsel_n = nsel + NSEL_W'(1);
                    if (left_ev && nsel != NSEL_W'(1))
                        nsel_n = nsel - NSEL_W'(1);
                end else if (FRAME_DONE && fcnt == AT_LAST) begin
                    state_n = S_ATTRACT;
                end
            end
            S_ATTRACT: begin
                if (start_ev || left_ev || right_ev)
                    state_n = S_INTRO;
            end
            S_IN_GAME: begin
                if (GAME_OVER) begin
                    mask_n = mask | (MAX_PLAYERS'(1) << active);
                    if (all_done(mask_n, nsel)) begin
                        state_n = S_GAME_OVER;
                    end else begin
                        state_n  = S_PLAYER_SWITCH;
                        active_n = next_player(active, nsel, mask_n);
                        ctx_n    = 1'b1;
                    end
                end else if (LIFE_LOST) begin
                    if (nsel > NSEL_W'(1)) begin
                        state_n  = S_PLAYER_SWITCH;
                        active_n = next_player(active, nsel, mask);
                        ctx_n    = 1'b1;
                    end
                end else if (pause_lvl) begin
                    state_n = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (!pause_lvl)
                    state_n = S_IN_GAME;
            end
            S_PLAYER_SWITCH: begin
                if (start_ev || (FRAME_DONE && fcnt == SW_LAST))
                    state_n = S_IN_GAME;
            end
            S_GAME_OVER: begin
                if (start_ev || (FRAME_DONE && fcnt == GO_LAST))
                    state_n = S_INTRO;
            end
            default: state_n = S_INTRO;
        endcase
        if (state_n != state)
            fcnt_n = '0;
        creset_n = (state_n == S_INTRO) || (state_n == S_ATTRACT) ||
                   (state_n == S_GAME_OVER);
        cpause_n = (state_n == S_PAUSED) || (state_n == S_PLAYER_SWITCH);
    end

    assign SCREEN        = state;
    assign ACTIVE_PLAYER = active;
    assign NUM_SELECTED  = nsel;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Directed bench for game_flow_sequencer with short debounce and frame timeouts.
`timescale 1ns/1ps
module tb_game_flow_sequencer;

    logic clk = 1'b0;
    logic reset, frame_done, btn_start, btn_left, btn_right;
    logic sw_pause, life_lost, game_over;
    logic [2:0] screen;
    logic [1:0] active_player;
    logic [2:0] num_selected;
    logic ctrl_reset, ctrl_pause, ctx_swap;
    int checks = 0;
    int errors = 0;

    game_flow_sequencer #(
        .NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4),
        .SWITCH_FRAMES(3), .GAMEOVER_FRAMES(5), .ATTRACT_FRAMES(8)
    ) dut (
        .CLK_40M(clk), .reset(reset), .FRAME_DONE(frame_done),
        .BTN_START(btn_start), .BTN_LEFT(btn_left), .BTN_RIGHT(btn_right),
        .SW_PAUSE(sw_pause), .LIFE_LOST(life_lost), .GAME_OVER(game_over),
        .SCREEN(screen), .ACTIVE_PLAYER(active_player),
        .NUM_SELECTED(num_selected), .CTRL_RESET(ctrl_reset),
        .CTRL_PAUSE(ctrl_pause), .CTX_SWAP(ctx_swap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // 0=start 1=left 2=right
    task automatic press(input int b);
        case (b)
            0: btn_start = 1'b1;
            1: btn_left  = 1'b1;
            default: btn_right = 1'b1;
        endcase
        tick(10);
        btn_start = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        tick(10);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_ll();
        life_lost = 1'b1;
        tick();
        life_lost = 1'b0;
    endtask

    task automatic pulse_go();
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_done = 1'b0; btn_start = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; sw_pause = 1'b0;
        life_lost = 1'b0; game_over = 1'b0;
        tick(3);
        reset = 1'b0;
        check("rst_screen", 32'(screen), 0);
        check("rst_active", 32'(active_player), 0);
        check("rst_nsel", 32'(num_selected), 1);
        check("rst_creset", 32'(ctrl_reset), 1);
        check("rst_cpause", 32'(ctrl_pause), 0);
        check("rst_ctx", 32'(ctx_swap), 0);
        tick(20);
        check("held_start", 32'(screen), 0);
        btn_start = 1'b0;
        tick(10);
        check("release_start", 32'(screen), 0);
        press(0);
        check("start_game", 32'(screen), 1);
        check("start_creset", 32'(ctrl_reset), 0);

        pulse_go();
        check("p1_gameover", 32'(screen), 2);
        frames(4);
        check("go_4frames", 32'(screen), 2);
        frames(1);
        check("go_5frames", 32'(screen), 0);

        press(2);
        check("right1", 32'(num_selected), 2);
        press(2);
        press(2);
        check("right3", 32'(num_selected), 2);
        press(1);
        check("left1", 32'(num_selected), 1);
        press(1);
        press(1);
        check("left3", 32'(num_selected), 1);
        for (int i = 0; i < 5; i++) begin
            btn_right = (i % 2 == 0);
            tick();
        end
        btn_right = 1'b0;
        tick(10);
        check("glitch", 32'(num_selected), 1);
        press(2);
        check("right_again", 32'(num_selected), 2);

        frames(7);
        check("idle7", 32'(screen), 0);
        frames(1);
        check("attract", 32'(screen), 5);
        press(0);
        check("attract_start", 32'(screen), 0);
        check("attract_nsel", 32'(num_selected), 2);

        press(0);
        check("game2", 32'(screen), 1);
        pulse_ll();
        check("ll_screen", 32'(screen), 4);
        check("ll_active", 32'(active_player), 1);
        check("ll_ctx", 32'(ctx_swap), 1);
        check("ll_cpause", 32'(ctrl_pause), 1);
        tick();
        check("ll_ctx_off", 32'(ctx_swap), 0);
        frames(2);
        check("sw_2frames", 32'(screen), 4);
        frames(1);
        check("sw_3frames", 32'(screen), 1);

        sw_pause = 1'b1;
        tick(10);
        check("paused", 32'(screen), 3);
        check("paused_cp", 32'(ctrl_pause), 1);
        pulse_ll();
        tick();
        check("pause_ll", 32'(screen), 3);
        pulse_go();
        tick();
        check("pause_go", 32'(screen), 3);
        check("pause_act", 32'(active_player), 1);
        sw_pause = 1'b0;
        tick(10);
        check("unpaused", 32'(screen), 1);

        game_over = 1'b1;
        life_lost = 1'b1;
        tick();
        game_over = 1'b0;
        life_lost = 1'b0;
        check("both_screen", 32'(screen), 4);
        check("both_active", 32'(active_player), 0);
        frames(3);
        check("both_resume", 32'(screen), 1);
        pulse_go();
        check("all_done", 32'(screen), 2);
        press(0);
        check("go_start", 32'(screen), 0);

        press(0);
        check("game3", 32'(screen), 1);
        check("game3_act", 32'(active_player), 0);
        pulse_go();
        check("p0_go", 32'(screen), 4);
        check("p0_go_act", 32'(active_player), 1);
        press(0);
        check("sw_start", 32'(screen), 1);
        pulse_ll();
        check("p1_ll", 32'(screen), 4);
        check("p1_ll_act", 32'(active_player), 1);
        frames(3);
        check("p1_resume", 32'(screen), 1);
        pulse_go();
        check("p1_go", 32'(screen), 2);
        check("p1_go_cr", 32'(ctrl_reset), 1);
        frames(5);
        check("p1_go_intro", 32'(screen), 0);

        press(0);
        check("game4", 32'(screen), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_screen", 32'(screen), 0);
        check("midrst_nsel", 32'(num_selected), 1);
        check("midrst_cr", 32'(ctrl_reset), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
